// File: rtl/mulx_pkg.sv
// Shared widths, T-term bit layout and the X-from-T reduction used by every mulx lane.
`define MULX_Q_SLICE(v, i) v[(i)*mulx_pkg::MULX_Q_W +: mulx_pkg::MULX_Q_W]
`define MULX_T_SLICE(v, i) v[(i)*mulx_pkg::MULX_T_W +: mulx_pkg::MULX_T_W]
`define MULX_X_SLICE(v, i) v[(i)*mulx_pkg::MULX_X_W +: mulx_pkg::MULX_X_W]

package mulx_pkg;
  localparam int MULX_Q_W = 18;
  localparam int MULX_X_W = 4;
  localparam int MULX_T_W = 8;

  // Position of each intermediate term inside a lane's T vector; T_N4 is ~(Q4&Q13).
  localparam int T_10 = 0;
  localparam int T_11 = 1;
  localparam int T_12 = 2;
  localparam int T_13 = 3;
  localparam int T_20 = 4;
  localparam int T_21 = 5;
  localparam int T_22 = 6;
  localparam int T_N4 = 7;

  function automatic logic [MULX_X_W-1:0] x_from_t(input logic [MULX_T_W-1:0] t);
    logic [MULX_X_W-1:0] x;
    x[0] = t[T_10] ^ t[T_20] ^ t[T_22];
    x[1] = t[T_11] ^ t[T_21] ^ t[T_20];
    x[2] = t[T_12] ^ t[T_21] ^ t[T_22];
    x[3] = t[T_13] ^ t[T_21] ^ t[T_N4];
    return x;
  endfunction
endpackage

// File: rtl/mulx_lane.sv
// One combinational GF(2^4) mulx lane: Q0..Q17 -> T-terms and X0..X3.
module mulx_lane
  import mulx_pkg::*;
(
  input  logic [MULX_Q_W-1:0] q,
  output logic [MULX_T_W-1:0] t,
  output logic [MULX_X_W-1:0] x
);
  assign t[T_20] = ~(q[6] & q[12]);
  assign t[T_21] = ~(q[3] & q[14]);
  assign t[T_22] = ~(q[1] & q[16]);
  assign t[T_10] = ~((q[3]  | q[14]) ^ ~(q[0]  & q[7]));
  assign t[T_11] = ~((q[4]  | q[13]) ^ ~(q[10] & q[11]));
  assign t[T_12] = ~((q[2]  | q[17]) ^ ~(q[5]  & q[9]));
  assign t[T_13] = ~((q[8]  | q[15]) ^ ~(q[2]  & q[17]));
  assign t[T_N4] = ~(q[4] & q[13]);

  assign x = x_from_t(t);
endmodule

// File: rtl/mulx_pipe.sv
// Multi-lane elastic mulx pipeline (1 or 2 register stages) with a shared valid/ready
// handshake and a tag that rides alongside each beat.
module mulx_pipe
  import mulx_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*MULX_Q_W-1:0] in_q,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*MULX_X_W-1:0] out_x,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      busy
);
  localparam int T_ALL = LANES * MULX_T_W;
  localparam int X_ALL = LANES * MULX_X_W;

  logic [T_ALL-1:0] t_p0;
  logic [X_ALL-1:0] x_p0;
  logic             vld_last;
  logic [X_ALL-1:0] x_last;
  logic [TAG_W-1:0] tag_last;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mulx_lane u_lane (
      .q (`MULX_Q_SLICE(in_q, i)),
      .t (`MULX_T_SLICE(t_p0, i)),
      .x (`MULX_X_SLICE(x_p0, i))
    );
  end

  if (PIPE_STAGES == 1) begin : g_pipe1
    logic             vld_p1_q, vld_p1_d, ld_p1;
    logic [X_ALL-1:0] x_p1_q;
    logic [TAG_W-1:0] tag_p1_q;
    logic             unused_t;

    assign unused_t = ^t_p0;

    always_comb begin
      in_ready = ~rst & (~vld_p1_q | out_ready);
      ld_p1    = in_valid & in_ready;
      vld_p1_d = ld_p1 | (vld_p1_q & ~out_ready);
    end

    // Stage 1: X registered straight from the lanes
    always_ff @(posedge clk) begin
      if (rst) vld_p1_q <= 1'b0;
      else     vld_p1_q <= vld_p1_d;
    end

    always_ff @(posedge clk) begin
      if (ld_p1) begin
        x_p1_q   <= x_p0;
        tag_p1_q <= in_tag;
      end
    end

    assign vld_last = vld_p1_q;
    assign x_last   = x_p1_q;
    assign tag_last = tag_p1_q;
    assign busy     = vld_p1_q;
  end else begin : g_pipe2
    logic             vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic             ld_p1, adv_p1;
    logic [T_ALL-1:0] t_p1_q;
    logic [TAG_W-1:0] tag_p1_q, tag_p2_q;
    logic [X_ALL-1:0] x_p1, x_p2_q;
    logic             unused_x;

    assign unused_x = ^x_p0;

    always_comb begin
      adv_p1   = vld_p1_q & (~vld_p2_q | out_ready);
      in_ready = ~rst & (~vld_p1_q | adv_p1);
      ld_p1    = in_valid & in_ready;
      vld_p1_d = ld_p1 | (vld_p1_q & ~adv_p1);
      vld_p2_d = adv_p1 | (vld_p2_q & ~out_ready);
    end

    always_comb begin
      x_p1 = '0;
      for (int i = 0; i < LANES; i++) begin
        `MULX_X_SLICE(x_p1, i) = x_from_t(`MULX_T_SLICE(t_p1_q, i));
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1_q <= 1'b0;
        vld_p2_q <= 1'b0;
      end else begin
        vld_p1_q <= vld_p1_d;
        vld_p2_q <= vld_p2_d;
      end
    end

    // Stage 1: T-terms and tag
    always_ff @(posedge clk) begin
      if (ld_p1) begin
        t_p1_q   <= t_p0;
        tag_p1_q <= in_tag;
      end
    end

    // Stage 2: X reduced from the registered T-terms
    always_ff @(posedge clk) begin
      if (adv_p1) begin
        x_p2_q   <= x_p1;
        tag_p2_q <= tag_p1_q;
      end
    end

    assign vld_last = vld_p2_q;
    assign x_last   = x_p2_q;
    assign tag_last = tag_p2_q;
    assign busy     = vld_p1_q | vld_p2_q;
  end

  // Data registers are never reset, so the outputs are zeroed whenever no beat is shown.
  assign out_valid = vld_last & ~rst;
  assign out_x     = out_valid ? x_last : '0;
  assign out_tag   = out_valid ? tag_last : '0;
endmodule

// File: tb/tb_mulx_pipe.sv
// Scoreboard bench for mulx_pipe: one instance per pipeline depth, driven side by side.
`timescale 1ns/1ps
module tb_mulx_pipe;
  localparam int LANES = 4;
  localparam int TAG_W = 8;
  localparam int QW    = LANES * 18;
  localparam int XW    = LANES * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input int ps, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL ps%0d %s actual=%0h required=%0h", ps, name, act, req);
    end
  endtask

  // Straight from the lane equations, one lane at a time.
  function automatic logic [XW-1:0] ref_x(input logic [QW-1:0] q);
    logic [XW-1:0] r;
    logic [17:0]   l;
    logic t10, t11, t12, t13, t20, t21, t22;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      l   = q[i*18 +: 18];
      t20 = ~(l[6] & l[12]);
      t21 = ~(l[3] & l[14]);
      t22 = ~(l[1] & l[16]);
      t10 = ~((l[3] | l[14]) ^ ~(l[0] & l[7]));
      t11 = ~((l[4] | l[13]) ^ ~(l[10] & l[11]));
      t12 = ~((l[2] | l[17]) ^ ~(l[5] & l[9]));
      t13 = ~((l[8] | l[15]) ^ ~(l[2] & l[17]));
      r[i*4 +: 4] = {t13 ^ t21 ^ ~(l[4] & l[13]), t12 ^ t21 ^ t22,
                     t11 ^ t21 ^ t20, t10 ^ t20 ^ t22};
    end
    return r;
  endfunction

  function automatic logic [QW-1:0] rand_q();
    logic [QW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*18 +: 18] = 18'($urandom());
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int PS = g + 1;
    logic               rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [QW-1:0]      in_q;
    logic [TAG_W-1:0]   in_tag, out_tag;
    logic [XW-1:0]      out_x;
    logic [XW+TAG_W-1:0] exp_q[$];
    int                 pop_cnt = 0;
    int                 pop_cyc[int];
    bit                 done = 1'b0;
    logic               stall_prev = 1'b0;
    logic [XW-1:0]      x_prev;
    logic [TAG_W-1:0]   tag_prev;

    mulx_pipe #(.LANES(LANES), .PIPE_STAGES(PS), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q),
      .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
      .out_tag(out_tag), .busy(busy)
    );

    // Monitor: pops the scoreboard on every output transfer and checks stall stability.
    always @(negedge clk) begin : mon
      logic [XW+TAG_W-1:0] e;
      if (!rst && stall_prev) begin
        check(PS, "hold_valid", 32'(out_valid), 32'd1);
        check(PS, "hold_x", 32'(out_x), 32'(x_prev));
        check(PS, "hold_tag", 32'(out_tag), 32'(tag_prev));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ps%0d unexpected_beat actual=%0h required=none", PS, {out_x, out_tag});
        end else begin
          e = exp_q.pop_front();
          check(PS, "beat", 32'({out_x, out_tag}), 32'(e));
        end
        pop_cnt++;
        pop_cyc[pop_cnt] = cyc;
      end
      stall_prev = out_valid & ~out_ready;
      x_prev     = out_x;
      tag_prev   = out_tag;
    end

    task automatic send(input logic [QW-1:0] q, input logic [TAG_W-1:0] tag, input bit push);
      int n = 0;
      in_valid = 1'b1;
      in_q     = q;
      in_tag   = tag;
      @(negedge clk);
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      check(PS, "accept", 32'(in_ready), 32'd1);
      if (in_ready && push) exp_q.push_back({ref_x(q), tag});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    endtask

    task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 500) begin
        @(posedge clk);
        #1;
        n++;
      end
      check(PS, "drained", 32'(exp_q.size()), 32'd0);
      check(PS, "busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin : main
      logic [QW-1:0]    v;
      logic [XW-1:0]    x0;
      logic [TAG_W-1:0] t0;
      int               acc, base, first, last;
      bit               acc_now, stop;

      rst = 1'b1; in_valid = 1'b1; in_q = rand_q(); in_tag = 8'h11; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check(PS, "rst_out_valid", 32'(out_valid), 32'd0);
      check(PS, "rst_out_x", 32'(out_x), 32'd0);
      check(PS, "rst_out_tag", 32'(out_tag), 32'd0);
      check(PS, "rst_busy", 32'(busy), 32'd0);
      check(PS, "rst_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check(PS, "post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Directed lane vector and latency.
      v = '0;
      v[0] = 1'b1; v[7] = 1'b1; v[22] = 1'b1; v[31] = 1'b1;
      v[QW-1:54] = '1;
      send(v, 8'hA5, 1'b1);
      check(PS, "lat_first_edge", 32'(out_valid), 32'(PS == 1));
      repeat (PS - 1) begin
        @(posedge clk);
        #1;
      end
      check(PS, "lat_valid", 32'(out_valid), 32'd1);
      check(PS, "vec_x", 32'(out_x), 32'(ref_x(v)));
      check(PS, "vec_tag", 32'(out_tag), 32'hA5);
      drain();

      // Back-to-back streaming.
      base = pop_cnt;
      for (int i = 0; i < 64; i++) begin
        in_valid = 1'b1; in_q = rand_q(); in_tag = 8'($urandom());
        @(negedge clk);
        check(PS, "stream_ready", 32'(in_ready), 32'd1);
        if (in_ready) exp_q.push_back({ref_x(in_q), in_tag});
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      drain();
      first = pop_cyc.exists(base + 1)  ? pop_cyc[base + 1]  : 0;
      last  = pop_cyc.exists(base + 64) ? pop_cyc[base + 64] : -1;
      check(PS, "stream_count", 32'(pop_cnt - base), 32'd64);
      check(PS, "stream_gapless", 32'(last - first), 32'd63);

      // Fill the pipe with the consumer stalled, hold, then release.
      out_ready = 1'b0; acc = 0;
      in_valid = 1'b1; in_q = rand_q(); in_tag = 8'($urandom());
      repeat (PS + 2) begin
        @(negedge clk);
        acc_now = in_ready;
        if (acc_now) begin
          exp_q.push_back({ref_x(in_q), in_tag});
          acc++;
        end
        @(posedge clk);
        #1;
        if (acc_now) begin
          in_q = rand_q(); in_tag = 8'($urandom());
        end
      end
      in_valid = 1'b0;
      check(PS, "fill_count", 32'(acc), 32'(PS));
      @(negedge clk);
      x0 = out_x; t0 = out_tag;
      repeat (5) begin
        @(negedge clk);
        check(PS, "bp_in_ready", 32'(in_ready), 32'd0);
        check(PS, "bp_out_valid", 32'(out_valid), 32'd1);
        check(PS, "bp_out_x", 32'(out_x), 32'(x0));
        check(PS, "bp_out_tag", 32'(out_tag), 32'(t0));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();

      // Random valid (30%) / ready (70%) duty.
      stop = 1'b0;
      fork
        begin
          for (int i = 0; i < 1000; i++) begin
            while ($urandom_range(99) >= 30) begin
              @(posedge clk);
              #1;
            end
            send(rand_q(), 8'($urandom()), 1'b1);
          end
          stop = 1'b1;
        end
        begin
          while (!stop) begin
            out_ready = ($urandom_range(99) < 70);
            @(posedge clk);
            #1;
          end
        end
      join
      out_ready = 1'b1;
      drain();

      // Reset with beats in flight; those beats must vanish.
      out_ready = 1'b0;
      in_valid = 1'b1; in_q = rand_q(); in_tag = 8'h77;
      repeat (2) begin
        @(negedge clk);
        acc_now = in_ready;
        @(posedge clk);
        #1;
        if (acc_now) begin
          in_q = rand_q(); in_tag = 8'h78;
        end
      end
      in_valid = 1'b0;
      check(PS, "flush_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check(PS, "flush_busy_after", 32'(busy), 32'd0);
      check(PS, "flush_out_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      send(rand_q(), 8'h3C, 1'b1);
      drain();
      done = 1'b1;
    end
  end

  initial begin : summary
    int n = 0;
    while (!(g_inst[0].done && g_inst[1].done) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (!(g_inst[0].done && g_inst[1].done)) begin
      checks++;
      errors++;
      $display("FAIL sim_timeout actual=%0d cycles required=completion", n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
